// File: rtl/cache_pkg.sv
// Shared state encoding, geometry constants and address helper for the cache miss sequencer.
package cache_pkg;

   localparam int CACHE_ADDR_W      = 32;
   localparam int CACHE_LINE_W      = 128;
   localparam int CACHE_OFFSET_BITS = 4;

   localparam logic MEM_WE_READ  = 1'b0;
   localparam logic MEM_WE_WRITE = 1'b1;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      WB_REQ   = 3'd1,
      WB_GAP   = 3'd2,
      FILL_REQ = 3'd3,
      REFILL   = 3'd4
   } miss_state_t;

   // Clears the byte-offset bits so the address points at the start of its line.
   function automatic logic [CACHE_ADDR_W-1:0] line_align(
      input logic [CACHE_ADDR_W-1:0] addr,
      input int                      offset_bits
   );
      logic [CACHE_ADDR_W-1:0] mask;
      mask = (CACHE_ADDR_W'(1) << offset_bits) - CACHE_ADDR_W'(1);
      return addr & ~mask;
   endfunction

endpackage

// File: rtl/cache_perf_counters.sv
// Three saturating 32-bit event counters for hit, miss and write-back activity.
module cache_perf_counters (
   input  logic        clk,
   input  logic        reset,
   input  logic        inc_hits,
   input  logic        inc_misses,
   input  logic        inc_writebacks,
   output logic [31:0] perf_hits,
   output logic [31:0] perf_misses,
   output logic [31:0] perf_writebacks
);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         perf_hits       <= '0;
         perf_misses     <= '0;
         perf_writebacks <= '0;
      end else begin
         if (inc_hits && (perf_hits != 32'hFFFF_FFFF))
            perf_hits <= perf_hits + 32'd1;
         if (inc_misses && (perf_misses != 32'hFFFF_FFFF))
            perf_misses <= perf_misses + 32'd1;
         if (inc_writebacks && (perf_writebacks != 32'hFFFF_FFFF))
            perf_writebacks <= perf_writebacks + 32'd1;
      end
   end

endmodule

// File: rtl/cache_miss_ctrl.sv
// Miss/refill sequencer for the write-back cache: stalls on a miss, writes back a dirty victim, fetches and installs the line.
// Optional event counters are built when CACHE_MISS_CTRL_PERF_EN is defined.
module cache_miss_ctrl
   import cache_pkg::*;
#(
   parameter int ADDR_W      = CACHE_ADDR_W,
   parameter int LINE_W      = CACHE_LINE_W,
   parameter int OFFSET_BITS = CACHE_OFFSET_BITS
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              read,
   input  logic              write,
   input  logic [ADDR_W-1:0] memoryaddress,
   input  logic              hit,
   input  logic              writeback_enable,
   input  logic [ADDR_W-1:0] writebackaddress,
   input  logic [LINE_W-1:0] writebackdata,
   output logic              stall_en,
   output logic              cachewrite_enable,
   output logic [LINE_W-1:0] mainmemorydata,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [LINE_W-1:0] mem_wdata,
   input  logic [LINE_W-1:0] mem_rdata,
   input  logic              mem_ack
`ifdef CACHE_MISS_CTRL_PERF_EN
   ,
   output logic [31:0]       perf_hits,
   output logic [31:0]       perf_misses,
   output logic [31:0]       perf_writebacks
`endif
);

   miss_state_t       state;
   miss_state_t       next_state;
   logic              access;
   logic              miss;
   logic [ADDR_W-1:0] miss_addr;
   logic [ADDR_W-1:0] wb_addr;
   logic [LINE_W-1:0] wb_data;
   logic [LINE_W-1:0] line_buf;

   assign access = read | write;
   assign miss   = access & ~hit;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         state <= IDLE;
      else
         state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:     if (miss) next_state = writeback_enable ? WB_REQ : FILL_REQ;
         WB_REQ:   if (mem_ack) next_state = WB_GAP;
         WB_GAP:   next_state = FILL_REQ;
         FILL_REQ: if (mem_ack) next_state = REFILL;
         REFILL:   next_state = IDLE;
         default:  next_state = IDLE;
      endcase
   end

   // Memory-side outputs depend only on state and latched registers, never on live CPU inputs.
   always_comb begin
      stall_en          = 1'b1;
      cachewrite_enable = 1'b0;
      mem_req           = 1'b0;
      mem_we            = MEM_WE_READ;
      mem_addr          = miss_addr;
      case (state)
         IDLE:     stall_en = miss & reset;
         WB_REQ: begin
            mem_req  = 1'b1;
            mem_we   = MEM_WE_WRITE;
            mem_addr = wb_addr;
         end
         WB_GAP:   mem_req = 1'b0;
         FILL_REQ: mem_req = 1'b1;
         REFILL:   cachewrite_enable = 1'b1;
         default:  stall_en = 1'b0;
      endcase
   end

   assign mem_wdata      = wb_data;
   assign mainmemorydata = line_buf;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         miss_addr <= '0;
         wb_addr   <= '0;
         wb_data   <= '0;
         line_buf  <= '0;
      end else begin
         if ((state == IDLE) && miss) begin
            miss_addr <= ADDR_W'(line_align(CACHE_ADDR_W'(memoryaddress), OFFSET_BITS));
            if (writeback_enable) begin
               wb_addr <= writebackaddress;
               wb_data <= writebackdata;
            end
         end
         if ((state == FILL_REQ) && mem_ack)
            line_buf <= mem_rdata;
      end
   end

`ifdef CACHE_MISS_CTRL_PERF_EN
   cache_perf_counters u_perf (
      .clk            (clk),
      .reset          (reset),
      .inc_hits       ((state == IDLE) && access && hit),
      .inc_misses     ((state == IDLE) && miss),
      .inc_writebacks ((state == WB_REQ) && mem_ack),
      .perf_hits      (perf_hits),
      .perf_misses    (perf_misses),
      .perf_writebacks(perf_writebacks)
   );
`endif

endmodule

// File: tb/tb_cache_miss_ctrl.sv
// Self-checking bench for cache_miss_ctrl: acts as CPU, cache and main memory, and predicts stall,
// memory traffic and installs from the access-level rules; perf counters are checked when CACHE_MISS_CTRL_PERF_EN is defined.
module tb_cache_miss_ctrl;

   logic         clk = 1'b0;
   logic         reset_n = 1'b0;
   logic         read = 1'b0;
   logic         write = 1'b0;
   logic [31:0]  memoryaddress = '0;
   logic         hit = 1'b0;
   logic         writeback_enable = 1'b0;
   logic [31:0]  writebackaddress = '0;
   logic [127:0] writebackdata = '0;
   logic         stall_en;
   logic         cachewrite_enable;
   logic [127:0] mainmemorydata;
   logic         mem_req;
   logic         mem_we;
   logic [31:0]  mem_addr;
   logic [127:0] mem_wdata;
   logic [127:0] mem_rdata = '0;
   logic         mem_ack = 1'b0;
`ifdef CACHE_MISS_CTRL_PERF_EN
   logic [31:0]  perf_hits;
   logic [31:0]  perf_misses;
   logic [31:0]  perf_writebacks;
`endif

   int n_compared = 0;
   int n_mismatched = 0;
   int model_hits = 0;
   int model_misses = 0;
   int model_wbs = 0;

   always #5 clk = ~clk;

   cache_miss_ctrl dut (
      .clk              (clk),
      .reset            (reset_n),
      .read             (read),
      .write            (write),
      .memoryaddress    (memoryaddress),
      .hit              (hit),
      .writeback_enable (writeback_enable),
      .writebackaddress (writebackaddress),
      .writebackdata    (writebackdata),
      .stall_en         (stall_en),
      .cachewrite_enable(cachewrite_enable),
      .mainmemorydata   (mainmemorydata),
      .mem_req          (mem_req),
      .mem_we           (mem_we),
      .mem_addr         (mem_addr),
      .mem_wdata        (mem_wdata),
      .mem_rdata        (mem_rdata),
      .mem_ack          (mem_ack)
`ifdef CACHE_MISS_CTRL_PERF_EN
      ,
      .perf_hits        (perf_hits),
      .perf_misses      (perf_misses),
      .perf_writebacks  (perf_writebacks)
`endif
   );

   function automatic logic [127:0] randLine();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
      n_compared++;
      assert (observed === expected) else begin
         n_mismatched++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   // One CPU access from presentation until stall drops, with the bench playing memory.
   task automatic applyStimulus(input logic rd, input logic wr, input logic [31:0] addr, input logic is_hit,
                                input logic dirty, input logic [31:0] victim_addr, input logic [127:0] victim_data,
                                input logic [127:0] fill_data, input int k_wb, input int k_fill,
                                input logic spurious_gap);
      int          exp_stalls, exp_reqs, exp_installs;
      int          stalls, reqs, installs, req_run, cycles;
      logic        in_wb, expect_gap, done, real_ack;
      logic [31:0] fill_addr;
      string       ph;
      fill_addr    = addr & 32'hFFFF_FFF0;
      exp_stalls   = is_hit ? 0 : 1 + (dirty ? k_wb + 1 : 0) + k_fill + 1;
      exp_reqs     = is_hit ? 0 : (dirty ? k_wb : 0) + k_fill;
      exp_installs = is_hit ? 0 : 1;
      stalls = 0; reqs = 0; installs = 0; req_run = 0; cycles = 0;
      in_wb = dirty && !is_hit; expect_gap = 1'b0; done = 1'b0; real_ack = 1'b0;
      read = rd; write = wr; memoryaddress = addr; hit = is_hit;
      writeback_enable = dirty; writebackaddress = victim_addr; writebackdata = victim_data;
      while (!done && cycles < 100) begin
         @(negedge clk);
         if (stall_en) stalls++;
         if (mem_req) reqs++;
         if (expect_gap) begin
            checkOutput("wb_gap_req", {127'd0, mem_req}, 128'd0);
            expect_gap = 1'b0;
            if (spurious_gap) begin
               mem_ack   = 1'b1;
               mem_rdata = randLine();
            end
         end else if (mem_req) begin
            req_run++;
            ph = in_wb ? "wb" : "fill";
            checkOutput({ph, "_we"}, {127'd0, mem_we}, {127'd0, in_wb});
            checkOutput({ph, "_addr"}, {96'd0, mem_addr}, {96'd0, in_wb ? victim_addr : fill_addr});
            if (in_wb) checkOutput("wb_data", mem_wdata, victim_data);
            if (req_run == (in_wb ? k_wb : k_fill)) begin
               mem_ack   = 1'b1;
               real_ack  = 1'b1;
               mem_rdata = in_wb ? randLine() : fill_data;
            end
         end
         if (cachewrite_enable) begin
            installs++;
            checkOutput("install_data", mainmemorydata, fill_data);
         end
         if (!stall_en) done = 1'b1;
         @(posedge clk); #1;
         if (real_ack) begin
            if (in_wb) begin
               in_wb      = 1'b0;
               expect_gap = 1'b1;
            end
            req_run  = 0;
            real_ack = 1'b0;
         end
         mem_ack   = 1'b0;
         mem_rdata = randLine();
         if (installs > 0) hit = 1'b1;
         cycles++;
      end
      checkOutput("done_in_budget", {127'd0, done}, 128'd1);
      checkOutput("stall_cycles", 128'(stalls), 128'(exp_stalls));
      checkOutput("req_cycles", 128'(reqs), 128'(exp_reqs));
      checkOutput("installs", 128'(installs), 128'(exp_installs));
      read = 1'b0; write = 1'b0; hit = 1'b0; writeback_enable = 1'b0;
      model_hits++;
      if (!is_hit) begin
         model_misses++;
         if (dirty) model_wbs++;
      end
   endtask

   task automatic spuriousIdleAck();
      @(negedge clk);
      mem_ack   = 1'b1;
      mem_rdata = randLine();
      checkOutput("idle_ack_req", {127'd0, mem_req}, 128'd0);
      @(posedge clk); #1;
      mem_ack = 1'b0;
      @(negedge clk);
      checkOutput("idle_ack_req_after", {127'd0, mem_req}, 128'd0);
      checkOutput("idle_ack_install", {127'd0, cachewrite_enable}, 128'd0);
      checkOutput("idle_ack_stall", {127'd0, stall_en}, 128'd0);
      @(posedge clk); #1;
   endtask

   task automatic resetMidFill(input logic [31:0] addr);
      int waited;
      read = 1'b1; hit = 1'b0; writeback_enable = 1'b0; memoryaddress = addr;
      waited = 0;
      do begin
         @(negedge clk);
         waited++;
      end while (!mem_req && waited < 20);
      checkOutput("fill_started", {127'd0, mem_req}, 128'd1);
      @(posedge clk); #2;
      reset_n = 1'b0;
      model_hits = 0; model_misses = 0; model_wbs = 0;
      #1;
      checkOutput("rst_mem_req", {127'd0, mem_req}, 128'd0);
      checkOutput("rst_stall", {127'd0, stall_en}, 128'd0);
      checkOutput("rst_install", {127'd0, cachewrite_enable}, 128'd0);
      checkOutput("rst_mem_addr", {96'd0, mem_addr}, 128'd0);
      checkOutput("rst_line", mainmemorydata, 128'd0);
      read = 1'b0;
      @(posedge clk); #1;
      reset_n = 1'b1;
      @(negedge clk);
      checkOutput("post_rst_req", {127'd0, mem_req}, 128'd0);
      checkOutput("post_rst_stall", {127'd0, stall_en}, 128'd0);
      @(posedge clk); #1;
   endtask

   initial begin
      logic        rd, is_hit, dirty, spur;
      logic [31:0] a, va;
      int          kw, kf;
      #2;
      read = 1'b1; hit = 1'b0;
      #1;
      checkOutput("reset_stall_forced", {127'd0, stall_en}, 128'd0);
      checkOutput("reset_mem_req", {127'd0, mem_req}, 128'd0);
      checkOutput("reset_mem_we", {127'd0, mem_we}, 128'd0);
      checkOutput("reset_install", {127'd0, cachewrite_enable}, 128'd0);
      checkOutput("reset_mem_addr", {96'd0, mem_addr}, 128'd0);
      checkOutput("reset_mem_wdata", mem_wdata, 128'd0);
      checkOutput("reset_line", mainmemorydata, 128'd0);
      read = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;

      applyStimulus(1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0, '0, '0, '0, 1, 1, 1'b0);
      applyStimulus(1'b1, 1'b0, 32'h0000_0014, 1'b0, 1'b0, '0, '0,
                    128'h0123_4567_89AB_CDEF_0F1E_2D3C_DEAD_BEEF, 1, 3, 1'b0);
      applyStimulus(1'b0, 1'b1, 32'h4206_9000, 1'b0, 1'b1, 32'h0000_0400, randLine(),
                    randLine(), 2, 2, 1'b1);
      spuriousIdleAck();

      for (int i = 0; i < 12; i++) begin
         rd     = 1'($urandom_range(0, 1));
         is_hit = ($urandom_range(0, 2) == 0);
         dirty  = 1'($urandom_range(0, 1));
         spur   = 1'($urandom_range(0, 1));
         a      = $urandom;
         va     = $urandom & 32'hFFFF_FFF0;
         kw     = $urandom_range(1, 4);
         kf     = $urandom_range(1, 4);
         applyStimulus(rd, ~rd, a, is_hit, dirty, va, randLine(), randLine(), kw, kf, spur);
      end

      resetMidFill(32'h0000_8888);
      applyStimulus(1'b1, 1'b0, 32'h0000_0100, 1'b1, 1'b0, '0, '0, '0, 1, 1, 1'b0);
      applyStimulus(1'b1, 1'b0, 32'h1234_567C, 1'b0, 1'b0, '0, '0, randLine(), 1, 1, 1'b0);
      applyStimulus(1'b0, 1'b1, 32'h0000_0200, 1'b1, 1'b1, 32'h0000_0300, randLine(), '0, 1, 1, 1'b0);
      applyStimulus(1'b0, 1'b1, 32'hABCD_0008, 1'b0, 1'b1, 32'h0000_0700, randLine(), randLine(), 3, 1, 1'b0);

`ifdef CACHE_MISS_CTRL_PERF_EN
      checkOutput("perf_hits", {96'd0, perf_hits}, 128'(model_hits));
      checkOutput("perf_misses", {96'd0, perf_misses}, 128'(model_misses));
      checkOutput("perf_writebacks", {96'd0, perf_writebacks}, 128'(model_wbs));
`endif
      $display("[TB] model events since last reset: hits=%0d misses=%0d writebacks=%0d",
               model_hits, model_misses, model_wbs);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
